// File: rtl/rx_pkg.sv
// Shared constants and helpers for the receive-side word path.
package rx_pkg;
  localparam int BYTE_W = 8;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word presented combinationally, 0 when empty.
module sync_fifo
  import rx_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = level_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the push needs, so full+push+pop proceeds
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/receiver_word_fifo.sv
// Packs received UART bytes into words and queues them for write-back,
// with byte-order select, partial-word timeout and sticky overflow.
module receiver_word_fifo
  import rx_pkg::*;
#(
  parameter  int WORD_BYTES     = 4,
  parameter  int DEPTH          = 4,
  parameter  bit BIG_ENDIAN     = 1'b1,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int W              = BYTE_W * WORD_BYTES,
  localparam int LW             = level_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              pop,
  input  logic              clear_overflow,
  output logic [W-1:0]      word_data,
  output logic              word_valid,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              partial_drop
);
  localparam int CW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] byte_cnt;
  logic [W-1:0]  asm_q, asm_next;
  logic [TW-1:0] idle_cnt;
  logic          last_byte, expire, drop;
  logic          fifo_full, fifo_empty;

  assign last_byte = rx_valid && (byte_cnt == CW'(WORD_BYTES - 1));

  generate
    if (WORD_BYTES == 1) begin : g_one
      assign asm_next = rx_data;
    end else if (BIG_ENDIAN) begin : g_be
      assign asm_next = {asm_q[W-BYTE_W-1:0], rx_data};
    end else begin : g_le
      assign asm_next = {rx_data, asm_q[W-1:BYTE_W]};
    end
  endgenerate

  // expiry edge is the one that would take the idle count to TIMEOUT_CYCLES;
  // a byte landing on that edge keeps the partial word alive
  assign expire = TO_EN && !rx_valid && (byte_cnt != '0) && (idle_cnt == TO_LAST);
  assign drop   = last_byte && fifo_full && !pop;

  always_ff @(posedge CLK) begin
    if (reset) begin
      byte_cnt     <= '0;
      asm_q        <= '0;
      idle_cnt     <= '0;
      overflow     <= 1'b0;
      partial_drop <= 1'b0;
    end else begin
      partial_drop <= expire;
      if (expire) begin
        byte_cnt <= '0;
        asm_q    <= '0;
        idle_cnt <= '0;
      end else if (rx_valid) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        asm_q    <= asm_next;
        idle_cnt <= '0;
      end else if (TO_EN && byte_cnt != '0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (last_byte),
    .pop   (pop),
    .din   (asm_next),
    .dout  (word_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign word_valid = ~fifo_empty;
endmodule

// File: tb/tb_receiver_word_fifo.sv
// Drives a big-endian/no-timeout and a little-endian/16-cycle-timeout instance
// with the same bytes and checks both against a queue-level model.
module tb_receiver_word_fifo;
  logic       CLK = 1'b0;
  logic       reset, rx_valid, pop, clear_overflow;
  logic [7:0] rx_data;
  logic [31:0] wd [2];
  logic        wv [2];
  logic [2:0]  lv [2];
  logic        ov [2];
  logic        pd [2];

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  receiver_word_fifo #(.WORD_BYTES(4), .DEPTH(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(0)) dut_be (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .pop(pop),
    .clear_overflow(clear_overflow), .word_data(wd[0]), .word_valid(wv[0]),
    .level(lv[0]), .overflow(ov[0]), .partial_drop(pd[0]));

  receiver_word_fifo #(.WORD_BYTES(4), .DEPTH(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(16)) dut_le (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .pop(pop),
    .clear_overflow(clear_overflow), .word_data(wd[1]), .word_valid(wv[1]),
    .level(lv[1]), .overflow(ov[1]), .partial_drop(pd[1]));

  // model: word list, pending byte list, idle count per instance
  int          mbe [2] = '{1, 0};
  int          mto [2] = '{0, 16};
  logic [31:0] mq  [2][4];
  int          mcnt[2];
  logic [7:0]  pb  [2][4];
  int          pcnt[2];
  int          idle[2];
  bit          movf[2];
  bit          mpd [2];
  bit          armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit popped, pushed, dropped;
      logic [31:0] w;
      if (reset) begin
        mcnt[i] = 0; pcnt[i] = 0; idle[i] = 0; movf[i] = 0; mpd[i] = 0;
      end else begin
        popped = pop && (mcnt[i] > 0);
        pushed = 0; dropped = 0; w = '0; mpd[i] = 0;
        if (rx_valid) begin
          pb[i][pcnt[i]] = rx_data;
          pcnt[i]++;
          idle[i] = 0;
          if (pcnt[i] == 4) begin
            w = mbe[i] ? {pb[i][0], pb[i][1], pb[i][2], pb[i][3]}
                       : {pb[i][3], pb[i][2], pb[i][1], pb[i][0]};
            pcnt[i] = 0;
            pushed  = 1;
          end
        end else if (pcnt[i] > 0) begin
          idle[i]++;
          if (mto[i] > 0 && idle[i] == mto[i]) begin
            pcnt[i] = 0; idle[i] = 0; mpd[i] = 1;
          end
        end else begin
          idle[i] = 0;
        end
        if (pushed && mcnt[i] == 4 && !popped) dropped = 1;
        if (popped) begin
          for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
          mcnt[i]--;
        end
        if (pushed && !dropped) begin
          mq[i][mcnt[i]] = w;
          mcnt[i]++;
        end
        if (dropped)             movf[i] = 1;
        else if (clear_overflow) movf[i] = 0;
      end
    end
    if (reset) armed = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("word_valid[%0d]", i), 32'(wv[i]), 32'(mcnt[i] > 0));
        chk($sformatf("word_data[%0d]", i), wd[i], (mcnt[i] > 0) ? mq[i][0] : 32'h0);
        chk($sformatf("level[%0d]", i), 32'(lv[i]), 32'(mcnt[i]));
        chk($sformatf("overflow[%0d]", i), 32'(ov[i]), 32'(movf[i]));
        chk($sformatf("partial_drop[%0d]", i), 32'(pd[i]), 32'(mpd[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[k*8 +: 8]);
  endtask

  task automatic pop_one();
    pop = 1'b1;
    cyc();
    pop = 1'b0;
  endtask

  function automatic logic [31:0] wk(input int k);
    return 32'hC0DE0000 + 32'(k);
  endfunction

  initial begin
    logic [31:0] w5;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; pop = 1'b0; clear_overflow = 1'b0;
    idle_n(2);
    reset = 1'b0;
    chk("rst valid", 32'(wv[0]), 32'h0);
    chk("rst level", 32'(lv[0]), 32'h0);
    chk("rst data",  wd[0], 32'h0);
    chk("rst ovf",   32'(ov[0]), 32'h0);

    // back-to-back bytes
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("t1 data be", wd[0], 32'h12345678);
    chk("t1 data le", wd[1], 32'h78563412);
    chk("t1 level",   32'(lv[0]), 32'h1);
    pop_one();
    chk("t1 popped valid", 32'(wv[0]), 32'h0);
    chk("t1 popped data",  wd[0], 32'h0);

    // gaps between bytes
    send(8'h12); idle_n(3); send(8'h34); idle_n(3); send(8'h56); idle_n(3); send(8'h78);
    chk("t2 data le", wd[1], 32'h78563412);
    chk("t2 data be", wd[0], 32'h12345678);
    pop_one();

    // overflow on 5th word, FIFO order preserved
    for (int k = 1; k <= 5; k++) send_word(wk(k));
    chk("t3 level", 32'(lv[0]), 32'h4);
    chk("t3 ovf",   32'(ov[0]), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t3 head %0d", k), wd[0], wk(k));
      pop_one();
    end
    chk("t3 drained", 32'(wv[0]), 32'h0);
    chk("t3 ovf sticky", 32'(ov[0]), 32'h1);
    clear_overflow = 1'b1; cyc(); clear_overflow = 1'b0;
    chk("t3 ovf clear", 32'(ov[0]), 32'h0);

    // full + push + pop
    for (int k = 1; k <= 4; k++) send_word(wk(k));
    w5 = wk(5);
    send(w5[31:24]); send(w5[23:16]); send(w5[15:8]);
    rx_data = w5[7:0]; rx_valid = 1'b1; pop = 1'b1;
    cyc();
    rx_valid = 1'b0; pop = 1'b0;
    chk("t4 level", 32'(lv[0]), 32'h4);
    chk("t4 ovf",   32'(ov[0]), 32'h0);
    chk("t4 head",  wd[0], wk(2));
    pop_one(); pop_one(); pop_one();
    chk("t4 tail", wd[0], wk(5));
    pop_one();

    // partial-word timeout
    send(8'hAA); send(8'hBB);
    idle_n(15);
    chk("t5 no drop yet", 32'(pd[1]), 32'h0);
    idle_n(1);
    chk("t5 drop pulse", 32'(pd[1]), 32'h1);
    chk("t5 level",      32'(lv[1]), 32'h0);
    idle_n(1);
    chk("t5 pulse ends", 32'(pd[1]), 32'h0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t5 data le",        wd[1], 32'h04030201);
    chk("t5 no timeout be",  wd[0], 32'hAABB0102);
    // byte on the expiry edge keeps the partial word
    send(8'hCC); idle_n(15); send(8'hDD);
    chk("t5 rx wins", 32'(pd[1]), 32'h0);
    idle_n(1);
    chk("t5 rx wins next", 32'(pd[1]), 32'h0);

    // reset mid-stream
    reset = 1'b1; cyc(); reset = 1'b0;
    send_word(wk(7)); send_word(wk(8));
    send(8'h11); send(8'h22); send(8'h33);
    chk("t6 pre level", 32'(lv[0]), 32'h2);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t6 level", 32'(lv[0]), 32'h0);
    chk("t6 valid", 32'(wv[0]), 32'h0);
    chk("t6 ovf",   32'(ov[0]), 32'h0);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    chk("t6 data be", wd[0], 32'hDEADBEEF);
    chk("t6 data le", wd[1], 32'hEFBEADDE);
    idle_n(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
